ram_queue_ctrl_3x78: RTL



---
 rtl/ram_queue_ctrl_3x78.sv | 96 +++++++++
 1 files changed

// File: rtl/ram_queue_ctrl_3x78.sv
// Pointer/occupancy control for a 3x78 FIFO built on an external ram_3x78.
// Define RAM_QUEUE_FLOW_EN to let an empty queue pass a beat straight through.
module ram_queue_ctrl_3x78 #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 78
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_enq_valid,
    output logic             io_enq_ready,
    input  logic [WIDTH-1:0] io_enq_bits,
    output logic             io_deq_valid,
    input  logic             io_deq_ready,
    output logic [WIDTH-1:0] io_deq_bits,
    output logic [1:0]       io_count,
    output logic [1:0]       ram_W0_addr,
    output logic             ram_W0_en,
    output logic             ram_W0_clk,
    output logic [WIDTH-1:0] ram_W0_data,
    output logic [1:0]       ram_R0_addr,
    output logic             ram_R0_en,
    output logic             ram_R0_clk,
    input  logic [WIDTH-1:0] ram_R0_data
);

    localparam logic [1:0] LAST = 2'(DEPTH - 1);

    logic [1:0] enq_ptr;
    logic [1:0] deq_ptr;
    logic       maybe_full;
    logic       ptr_match;
    logic       empty;
    logic       full;
    logic       do_enq;
    logic       do_deq;
    logic [2:0] count_wide;

    assign ptr_match = (enq_ptr == deq_ptr);
    assign empty     = ptr_match & ~maybe_full;
    assign full      = ptr_match & maybe_full;

    assign io_enq_ready = ~full;

`ifdef RAM_QUEUE_FLOW_EN
    // An empty queue forwards the producer beat; it only lands in RAM if unaccepted.
    assign io_deq_valid = ~empty | io_enq_valid;
    assign io_deq_bits  = empty ? io_enq_bits : ram_R0_data;
    assign do_enq = io_enq_valid & io_enq_ready & ~(empty & io_deq_ready);
    assign do_deq = ~empty & io_deq_ready;
`else
    assign io_deq_valid = ~empty;
    assign io_deq_bits  = ram_R0_data;
    assign do_enq = io_enq_valid & io_enq_ready;
    assign do_deq = io_deq_valid & io_deq_ready;
`endif

    assign ram_W0_addr = enq_ptr;
    assign ram_W0_en   = do_enq;
    assign ram_W0_clk  = clock;
    assign ram_W0_data = io_enq_bits;
    assign ram_R0_addr = deq_ptr;
    assign ram_R0_en   = ~empty;
    assign ram_R0_clk  = clock;

    always_comb begin
        count_wide = 3'd0;
        if (ptr_match) begin
            count_wide = maybe_full ? 3'(DEPTH) : 3'd0;
        end else if (enq_ptr > deq_ptr) begin
            count_wide = {1'b0, enq_ptr} - {1'b0, deq_ptr};
        end else begin
            count_wide = 3'(DEPTH) + {1'b0, enq_ptr} - {1'b0, deq_ptr};
        end
    end

    assign io_count = count_wide[1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            enq_ptr    <= 2'd0;
            deq_ptr    <= 2'd0;
            maybe_full <= 1'b0;
        end else begin
            if (do_enq) begin
                enq_ptr <= (enq_ptr == LAST) ? 2'd0 : enq_ptr + 2'd1;
            end
            if (do_deq) begin
                deq_ptr <= (deq_ptr == LAST) ? 2'd0 : deq_ptr + 2'd1;
            end
            if (do_enq != do_deq) begin
                maybe_full <= do_enq;
            end
        end
    end

endmodule
